// File: rtl/shift_unit.sv
// Multi-cycle shifter: loads a count and an operand from a shared bus, then
// shifts by up to STEP positions per cycle until the count reaches zero.
module shift_unit #(
   parameter int W = 32,
   parameter int STEP = 1,
   localparam int CW = $clog2(W) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [W-1:0]  bus_in,
   input  logic          ld_cnt,
   input  logic          ld_data,
   input  logic [1:0]    mode,
   input  logic          start,
   input  logic          abort,
   output logic [W-1:0]  data_out,
   output logic [CW-1:0] cnt_out,
   output logic          busy,
   output logic          done,
   output logic          n
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [CW-1:0] STEP_C = CW'(STEP);

   state_t        state_q, state_d;
   logic [W-1:0]  data_q, data_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    mode_q, mode_d;
   logic [CW-1:0] amt;
   logic [W-1:0]  shifted;

   assign amt = (cnt_q < STEP_C) ? cnt_q : STEP_C;

   // amt is never zero while shifting, so the rotate's W-amt term stays below W.
   always_comb begin
      shifted = data_q;
      unique case (mode_q)
         2'b00: shifted = data_q >> amt;
         2'b01: shifted = $signed(data_q) >>> amt;
         2'b10: shifted = data_q << amt;
         2'b11: shifted = (data_q << amt) | (data_q >> (W - int'(amt)));
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         mode_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

   // A load in IDLE takes priority over start in the same cycle.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      unique case (state_q)
         IDLE: begin
            if (ld_cnt || ld_data) begin
               if (ld_cnt)  cnt_d  = {1'b0, bus_in[CW-2:0]};
               if (ld_data) data_d = bus_in;
            end else if (start) begin
               mode_d  = mode;
               state_d = (cnt_q != '0) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            if (abort) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               data_d = shifted;
               cnt_d  = cnt_q - amt;
               if (cnt_q == amt) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == SHIFT);
      done = (state_q == DONE);
   end

   assign n        = (cnt_q == '0);
   assign data_out = data_q;
   assign cnt_out  = cnt_q;

endmodule

// File: tb/tb_shift_unit.sv
// Drives two shift_unit instances (STEP=1 and STEP=4) from shared inputs and
// checks both against a transaction-level model every cycle.
module tb_shift_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] bus_in;
   logic        ld_cnt, ld_data, start, abort;
   logic [1:0]  mode;

   logic [31:0] data1, data4;
   logic [5:0]  cnt1, cnt4;
   logic        busy1, busy4, done1, done4, n1, n4;

   int assertCount = 0;
   int failCount   = 0;
   bit checkEn     = 1'b0;
   int busyCnt[2];
   int doneCnt[2];

   // Model: 0 idle, 1 shifting, 2 done; shifting state is kept as start values plus elapsed cycles.
   int          mState[2];
   logic [31:0] mData[2];
   logic [31:0] mData0[2];
   int          mCnt[2];
   int          mCnt0[2];
   int          mElapsed[2];
   logic [1:0]  mMode[2];

   shift_unit #(.W(32), .STEP(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .ld_cnt(ld_cnt), .ld_data(ld_data),
      .mode(mode), .start(start), .abort(abort), .data_out(data1), .cnt_out(cnt1),
      .busy(busy1), .done(done1), .n(n1)
   );

   shift_unit #(.W(32), .STEP(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .ld_cnt(ld_cnt), .ld_data(ld_data),
      .mode(mode), .start(start), .abort(abort), .data_out(data4), .cnt_out(cnt4),
      .busy(busy4), .done(done4), .n(n4)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] refShift(logic [31:0] d, int amt, logic [1:0] md);
      if (amt == 0) return d;
      case (md)
         2'b00:   return d >> amt;
         2'b01:   return $signed(d) >>> amt;
         2'b10:   return d << amt;
         default: return (d << amt) | (d >> (32 - amt));
      endcase
   endfunction

   task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic modelStep(int k, int step);
      int consumed;
      case (mState[k])
         0: begin
            if (ld_cnt || ld_data) begin
               if (ld_cnt)  mCnt[k]  = int'(bus_in[4:0]);
               if (ld_data) mData[k] = bus_in;
            end else if (start) begin
               mMode[k]    = mode;
               mData0[k]   = mData[k];
               mCnt0[k]    = mCnt[k];
               mElapsed[k] = 0;
               mState[k]   = (mCnt[k] > 0) ? 1 : 2;
            end
         end
         1: begin
            if (abort) begin
               mCnt[k]   = 0;
               mState[k] = 0;
            end else begin
               mElapsed[k]++;
               consumed  = (mElapsed[k] * step < mCnt0[k]) ? mElapsed[k] * step : mCnt0[k];
               mData[k]  = refShift(mData0[k], consumed, mMode[k]);
               mCnt[k]   = mCnt0[k] - consumed;
               if (mCnt[k] == 0) mState[k] = 2;
            end
         end
         default: mState[k] = 0;
      endcase
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            mState[k] = 0;
            mData[k]  = '0;
            mCnt[k]   = 0;
            mMode[k]  = 2'b00;
         end
      end else begin
         modelStep(0, 1);
         modelStep(1, 4);
      end
   end

   task automatic compareInst(string tag, int k, logic [31:0] d, logic [5:0] c,
                              logic b, logic dn, logic nn);
      checkOutput({tag, ".data"}, d, mData[k]);
      checkOutput({tag, ".cnt"}, 32'(c), 32'(mCnt[k]));
      checkOutput({tag, ".busy"}, 32'(b), 32'(mState[k] == 1));
      checkOutput({tag, ".done"}, 32'(dn), 32'(mState[k] == 2));
      checkOutput({tag, ".n"}, 32'(nn), 32'(mCnt[k] == 0));
   endtask

   initial forever begin
      @(negedge clk);
      if (checkEn && rst_n) begin
         compareInst("step1", 0, data1, cnt1, busy1, done1, n1);
         compareInst("step4", 1, data4, cnt4, busy4, done4, n4);
         busyCnt[0] += int'(busy1);
         busyCnt[1] += int'(busy4);
         doneCnt[0] += int'(done1);
         doneCnt[1] += int'(done4);
      end
   end

   task automatic applyStimulus(logic ldc, logic ldd, logic st, logic ab,
                                logic [1:0] md, logic [31:0] bus);
      ld_cnt  = ldc;
      ld_data = ldd;
      start   = st;
      abort   = ab;
      mode    = md;
      bus_in  = bus;
      @(posedge clk);
      #2;
      ld_cnt  = 1'b0;
      ld_data = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
   endtask

   task automatic settle(int cycles);
      repeat (cycles) @(posedge clk);
      #2;
   endtask

   task automatic clearCounts();
      busyCnt = '{0, 0};
      doneCnt = '{0, 0};
   endtask

   task automatic loadOperands(logic [31:0] d, logic [31:0] c, logic [1:0] md);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, md, d);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, md, c);
   endtask

   task automatic runOp(logic [31:0] d, logic [31:0] c, logic [1:0] md);
      loadOperands(d, c, md);
      clearCounts();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, md, 32'h0);
      settle(40);
   endtask

   initial begin
      rst_n = 1'b0;
      bus_in = '0; ld_cnt = 1'b0; ld_data = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'b00;
      clearCounts();
      settle(2);
      checkOutput("reset.data", data1, 32'h0);
      checkOutput("reset.cnt", 32'(cnt1), 32'h0);
      checkOutput("reset.busy", 32'(busy1), 32'h0);
      checkOutput("reset.done", 32'(done1), 32'h0);
      checkOutput("reset.n", 32'(n1), 32'h1);
      rst_n = 1'b1;
      checkEn = 1'b1;
      settle(1);

      runOp(32'h80000001, 32'd4, 2'b01);
      checkOutput("asr.data1", data1, 32'hF8000000);
      checkOutput("asr.busy1", busyCnt[0], 4);
      checkOutput("asr.done1", doneCnt[0], 1);
      checkOutput("asr.n1", 32'(n1), 32'h1);
      checkOutput("asr.data4", data4, 32'hF8000000);
      checkOutput("asr.busy4", busyCnt[1], 1);

      runOp(32'h0000000F, 32'd6, 2'b10);
      checkOutput("lsl.data4", data4, 32'h000003C0);
      checkOutput("lsl.busy4", busyCnt[1], 2);
      checkOutput("lsl.done4", doneCnt[1], 1);
      checkOutput("lsl.data1", data1, 32'h000003C0);
      checkOutput("lsl.busy1", busyCnt[0], 6);

      runOp(32'h80000001, 32'd1, 2'b11);
      checkOutput("rol1.data1", data1, 32'h00000003);

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 32'h0);
      clearCounts();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 32'h0);
      #4;
      checkOutput("cnt0.done_next", 32'(done1), 32'h1);
      checkOutput("cnt0.busy_next", 32'(busy1), 32'h0);
      settle(5);
      checkOutput("cnt0.busycount", busyCnt[0], 0);
      checkOutput("cnt0.donecount", doneCnt[0], 1);
      checkOutput("cnt0.data1", data1, 32'h00000003);

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'hFFFFFFE5);
      checkOutput("cntload.upper_ignored", 32'(cnt1), 32'd5);

      clearCounts();
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 32'd3);
      checkOutput("ldstart.busy", 32'(busy1), 32'h0);
      checkOutput("ldstart.cnt", 32'(cnt1), 32'd3);
      settle(3);
      checkOutput("ldstart.nodone", doneCnt[0], 0);

      loadOperands(32'hFF000000, 32'd8, 2'b00);
      clearCounts();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0);
      settle(3);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0);
      settle(10);
      checkOutput("abort.data1", data1, 32'h1FE00000);
      checkOutput("abort.cnt1", 32'(cnt1), 32'h0);
      checkOutput("abort.nodone1", doneCnt[0], 0);
      checkOutput("abort.data4", data4, 32'h00FF0000);
      checkOutput("abort.done4", doneCnt[1], 1);

      loadOperands(32'h80000001, 32'd4, 2'b00);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 32'h00001234);
      settle(10);
      checkOutput("ldbusy.data1", data1, 32'h08000000);
      checkOutput("ldbusy.data4", data4, 32'h08000000);

      runOp(32'h12345678, 32'd31, 2'b11);
      checkOutput("rol31.data1", data1, 32'h091A2B3C);
      checkOutput("rol31.busy1", busyCnt[0], 31);
      checkOutput("rol31.busy4", busyCnt[1], 8);

      loadOperands(32'hFF000000, 32'd8, 2'b00);
      clearCounts();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rstmid.data1", data1, 32'h0);
      checkOutput("rstmid.busy1", 32'(busy1), 32'h0);
      checkOutput("rstmid.cnt1", 32'(cnt1), 32'h0);
      checkOutput("rstmid.n1", 32'(n1), 32'h1);
      #1;
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h000000A5);
      checkOutput("rstmid.reload1", data1, 32'h000000A5);
      checkOutput("rstmid.reload4", data4, 32'h000000A5);
      checkOutput("rstmid.nodone1", doneCnt[0], 0);
      settle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
